// File: rtl/div_pkg.sv
// Shared constants, state encoding and negation helper for the iterative divider.
package div_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  localparam logic [WIDTH-1:0] DIV_ZERO_Q = 32'hFFFFFFFF;
  localparam logic [WIDTH-1:0] INT_MIN    = 32'h80000000;
  localparam logic [CNT_W-1:0] ITER_LAST  = 6'd31;

  function automatic logic [WIDTH-1:0] neg32(input logic [WIDTH-1:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/AdderSuber32.sv
// 32-bit adder-subtractor: result = a + b (sub=0) or a - b (sub=1); cout=1 on no borrow when subtracting.
module AdderSuber32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] result,
  output logic        cout,
  output logic        overflow,
  output logic        zero
);

  logic [31:0] w_b;
  logic [32:0] w_sum;

  assign w_b      = b ^ {32{sub}};
  assign w_sum    = {1'b0, a} + {1'b0, w_b} + {32'd0, sub};
  assign result   = w_sum[31:0];
  assign cout     = w_sum[32];
  assign overflow = (a[31] == w_b[31]) && (result[31] != a[31]);
  assign zero     = (result == 32'd0);

endmodule

// File: rtl/div_iter32.sv
// Iterative 32-bit restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional macro DIV_FLUSH_EN adds a flush input that aborts any operation.
module div_iter32
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
`ifdef DIV_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        busy
);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_p;
  logic [31:0]      r_q;
  logic [31:0]      r_d;
  logic             r_q_neg;
  logic             r_r_neg;
  logic [31:0]      r_quotient;
  logic [31:0]      r_remainder;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             r_busy;

  logic        w_flush;
  logic [32:0] w_p_shift;
  logic [31:0] w_sum;
  logic        w_cout;
  logic        w_accept_bit;
  logic        w_unused_ovf;
  logic        w_unused_zero;
  logic [31:0] w_dvd_abs;
  logic [31:0] w_dvs_abs;

`ifdef DIV_FLUSH_EN
  assign w_flush  = flush;
  assign in_ready = r_in_ready & ~flush;
`else
  assign w_flush  = 1'b0;
  assign in_ready = r_in_ready;
`endif

  assign out_valid = r_out_valid;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign busy      = r_busy;

  assign w_dvd_abs = (is_signed && dividend[31]) ? neg32(dividend) : dividend;
  assign w_dvs_abs = (is_signed && divisor[31])  ? neg32(divisor)  : divisor;

  // Bit 32 of the shifted remainder means it already exceeds any 32-bit divisor.
  assign w_p_shift    = {r_p, r_q[31]};
  assign w_accept_bit = w_cout | w_p_shift[32];

  AdderSuber32 u_addsub (
    .a        (w_p_shift[31:0]),
    .b        (r_d),
    .sub      (1'b1),
    .result   (w_sum),
    .cout     (w_cout),
    .overflow (w_unused_ovf),
    .zero     (w_unused_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 6'd0;
      r_p         <= 32'd0;
      r_q         <= 32'd0;
      r_d         <= 32'd0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_quotient  <= 32'd0;
      r_remainder <= 32'd0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else if (w_flush) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 6'd0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_q_neg    <= is_signed & (dividend[31] ^ divisor[31]);
            r_r_neg    <= is_signed & dividend[31];
            r_p        <= 32'd0;
            r_q        <= w_dvd_abs;
            r_d        <= w_dvs_abs;
            r_cnt      <= 6'd0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (divisor == 32'd0) begin
              r_quotient  <= DIV_ZERO_Q;
              r_remainder <= dividend;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else if (is_signed && dividend == INT_MIN && divisor == 32'hFFFFFFFF) begin
              r_quotient  <= INT_MIN;
              r_remainder <= 32'd0;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_p   <= w_accept_bit ? w_sum : w_p_shift[31:0];
          r_q   <= {r_q[30:0], w_accept_bit};
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == ITER_LAST) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_quotient  <= r_q_neg ? neg32(r_q) : r_q;
          r_remainder <= r_r_neg ? neg32(r_p) : r_p;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter32.sv
// Scoreboard bench for div_iter32: directed corner cases plus randomized operands and backpressure.
module tb_div_iter32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
`ifdef DIV_FLUSH_EN
  logic        flush;
`endif

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  logic prev_ov  = 1'b0;
  logic rnd_bp   = 1'b0;

  div_iter32 dut (
    .clk       (clk),
    .rst       (rst),
`ifdef DIV_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Reference: plain RISC-V division semantics, special cases answered immediately.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    int   sa;
    int   sd;
    if (b == 32'd0) begin
      e.q = 32'hFFFFFFFF; e.r = a; e.lat = 1;
    end else if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      e.q = 32'h80000000; e.r = 32'd0; e.lat = 1;
    end else if (s) begin
      sa = $signed(a); sd = $signed(b);
      e.q = sa / sd; e.r = sa % sd; e.lat = 34;
    end else begin
      e.q = a / b; e.r = a % b; e.lat = 34;
    end
    return e;
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, output int waits);
    waits = 0;
    dividend = a; divisor = b; is_signed = s; in_valid = 1'b1;
    sb.push_back(model(a, b, s));
    while (!in_ready && waits < 300) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      void'(sb.pop_back());
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
      dividend = $urandom; divisor = $urandom;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
  endtask

  // Monitor: checks latency when a result appears and values on the handshake.
  always begin
    @(negedge clk);
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
        else chk("latency", cyc - acc_cyc + 1, sb[0].lat);
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        chk("quotient", quotient, sb[0].q);
        chk("remainder", remainder, sb[0].r);
        void'(sb.pop_front());
      end
      prev_ov = out_valid;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    int w;
    logic [31:0] a;
    logic [31:0] b;
    logic s;
    rst = 1'b1; in_valid = 1'b0; dividend = 32'd0; divisor = 32'd0;
    is_signed = 1'b0; out_ready = 1'b1;
`ifdef DIV_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(32'd100, 32'd7, 1'b0, w);
    do_op(32'hFFFFFFF9, 32'd2, 1'b1, w);
    do_op(32'd7, 32'hFFFFFFFE, 1'b1, w);
    do_op(32'd5, 32'd0, 1'b1, w);
    do_op(32'd5, 32'd0, 1'b0, w);
    do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, w);
    do_op(32'h80000000, 32'hFFFFFFFF, 1'b0, w);
    do_op(32'd0, 32'hFFFFFFFB, 1'b1, w);
    do_op(32'hFFFFFFFF, 32'd1, 1'b0, w);
    wait_drain();

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    do_op(32'd100, 32'd7, 1'b0, w);
    w = 0;
    while (!out_valid && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_quotient", quotient, 32'd14);
      chk("bp_remainder", remainder, 32'd2);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    do_op(32'd20, 32'd3, 1'b0, w);
    chk("bp_next_accept_waits", w, 32'd0);
    wait_drain();

    // Reset in the middle of CALC.
    do_op(32'd12345, 32'd17, 1'b0, w);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_quotient", quotient, 32'd0);
    chk("mid_rst_remainder", remainder, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
    end

`ifdef DIV_FLUSH_EN
    do_op(32'd54321, 32'd9, 1'b0, w);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready_after", {31'd0, in_ready}, 32'd1);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    repeat (40) begin
      @(negedge clk);
      chk("post_flush_no_valid", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    do_op(32'hFFFFFFFF, 32'd1, 1'b0, w);
    wait_drain();
`endif

    // Randomized operands with random consumer backpressure.
    rnd_bp = 1'b1;
    repeat (40) begin
      case ($urandom_range(0, 7))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = $urandom; b = $urandom_range(1, 15); end
        3: begin a = $urandom_range(0, 50); b = $urandom; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      s = 1'($urandom_range(0, 1));
      do_op(a, b, s, w);
    end
    wait_drain();
    rnd_bp = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_iter32.md
Name: div_iter32

Overview:
- Iterative 32-bit restoring divider for the NPC EXU M-extension path (DIV/DIVU/REM/REMU).
- Sits directly upstream of the existing 32-bit adder-subtractor (AdderSuber32). Each iteration it drives a and b with sub=1, then consumes result and cout (no borrow ⇔ partial remainder ≥ divisor).
- Valid/ready handshake on both sides; one division in flight.

Parameters:
- WIDTH, 32, operand width; only 32 supported (fixed by the adder-subtractor).
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operands valid
- in_ready  output  1  divider can accept (high only in IDLE)
- dividend  input  32  dividend (rs1)
- divisor  input  32  divisor (rs2)
- is_signed  input  1  1 = DIV/REM, 0 = DIVU/REMU
- out_valid  output  1  quotient/remainder valid
- out_ready  input  1  consumer accepts result
- quotient  output  32  quotient
- remainder  output  32  remainder
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=1, out_valid=0, busy=0, quotient=0, remainder=0, counter=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE: on in_valid&&in_ready, latch operands and sign info.
  - Signed mode: take absolute values. Record q_neg = sign(dividend)^sign(divisor) and r_neg = sign(dividend).
  - divisor==0 → DONE with quotient=32'hFFFFFFFF, remainder=dividend (raw).
  - Signed, dividend==32'h80000000 and divisor==32'hFFFFFFFF → DONE with quotient=32'h80000000, remainder=0.
  - Otherwise → CALC, counter=0, partial remainder P=0, Q=|dividend|.
- CALC, one iteration per cycle:
  - Form {P',Q'} = {P,Q}<<1.
  - Drive a=P'[31:0], b=|divisor|, sub=1.
  - If cout=1 or P'[32]=1: P=result, Q'[0]=1. Else P=P'[31:0], Q'[0]=0.
  - P is held 33 bits wide for the shift; the adder sees the low 32 bits; the 33rd bit forces subtract-accept.
  - After 32 iterations (counter==31) → FIX.
- FIX, 1 cycle: quotient = q_neg ? -Q : Q; remainder = r_neg ? -P : P (two's complement, 32-bit wrap). → DONE.
- DONE: out_valid=1. quotient and remainder hold stable until out_valid&&out_ready, then → IDLE. in_ready stays 0 while in DONE.
- Latency from accept:
  - Normal: out_valid in cycle 34 (1 accept + 32 CALC + 1 FIX).
  - Special cases: out_valid in cycle 1.
- Back-to-back: result handshake in DONE returns to IDLE. The next accept is in the following cycle; no combinational in_ready←out_ready path.
- in_valid without in_ready is ignored. Operand changes while busy have no effect.
- out_ready asserted outside DONE has no effect.
- rst mid-operation: immediate return to reset state; partial result discarded, no out_valid.
- Signed zero dividend gives q=0, r=0; no negative-zero issue.

Optional Feature:
- Macro DIV_FLUSH_EN adds input port flush (1 bit).
- Defined: flush=1 in any state forces IDLE next cycle, drops out_valid, and discards the result. flush has priority over in_valid and out_ready in the same cycle. in_ready is 0 in the flush cycle.
- Undefined: no flush port; a division can only be terminated by rst.

Decomposition:
- Shared package div_pkg:
  - state encoding (IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3)
  - DIV_ZERO_Q=32'hFFFFFFFF
  - INT_MIN=32'h80000000
  - ITER_LAST=31
- Sub-module: one instance of the existing AdderSuber32, sub tied to 1; overflow and zero outputs unused.
- Negation in FIX uses local two's-complement logic; the adder is not time-shared.

Test Plan:
- Unsigned: 100 / 7, is_signed=0 → quotient=14, remainder=2; out_valid exactly 34 cycles after accept.
- Signed: -7 (0xFFFFFFF9) / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; 7 / -2 → quotient=0xFFFFFFFD, remainder=1.
- Divide by zero: 5 / 0, signed and unsigned → quotient=0xFFFFFFFF, remainder=5, out_valid 1 cycle after accept.
- Signed overflow: 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0; the same operands unsigned → quotient=0, remainder=0x80000000 after 34 cycles.
- Backpressure: out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0. Then out_ready=1 → IDLE next cycle; a new in_valid is accepted the cycle after.
- Reset/flush: rst pulse at CALC iteration 10 → outputs at reset values, in_ready=1, no out_valid. With DIV_FLUSH_EN, flush at iteration 10 → same outcome, and the next division 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0.
